sid_audio_decimator: RTL
========================

# sid_audio_decimator

Downstream stage of the SID core. It takes the 18-bit unsigned `audio_data` word, sampled on every `ce_1m` strobe, and box-car averages blocks of 2^LOG2_DECIM samples. Each averaged sample is pushed into a 4-entry output FIFO. The FIFO is drained over a valid/ready handshake by the audio mixer/I2S path, which decouples the ~1 MHz SID sample rate from the consumer's pace.

## Interface
Parameters:
- LOG2_DECIM, 4, log2 of the decimation factor; the block averages 2^LOG2_DECIM input samples per output (legal range 1..6).
- SIGNED_OUT, 1, 1 = output offset-binary converted to two's complement (invert bit 17); 0 = unsigned passthrough.

Ports:
- clk  in  1  system clock; one clock domain for the whole block.
- reset  in  1  reset, asynchronous and active-high.
- ce_1m  in  1  1 MHz sample strobe; one-cycle pulse.
- en  in  1  accumulate enable; while low, the accumulator and counter are held at 0.
- audio_in  in  18  unsigned SID output, valid on cycles where ce_1m is high.
- out_ready  in  1  consumer accepts the head sample this cycle.
- clr_ovf  in  1  clears the sticky overflow flag.
- out_valid  out  1  FIFO not empty.
- out_data  out  18  FIFO head sample.
- level  out  3  FIFO occupancy, 0..4.
- overflow  out  1  sticky flag: a completed sample was dropped because the FIFO was full.

## Operation
- Accumulator `acc` is 18+LOG2_DECIM bits wide. Block counter `cnt` is LOG2_DECIM bits wide.
- On a cycle with ce_1m=1 and en=1:
  - If cnt ≠ 2^LOG2_DECIM−1: acc ← acc + audio_in, cnt ← cnt+1.
  - If cnt = 2^LOG2_DECIM−1: the sample avg = (acc + audio_in) >> LOG2_DECIM, truncated to 18 bits. avg is pushed; then acc ← 0 and cnt ← 0.
- The accumulator never overflows, because its width covers 2^LOG2_DECIM × (2^18−1). The division truncates; there is no rounding.
- Pushed value: {~avg[17], avg[16:0]} when SIGNED_OUT=1, otherwise avg.
- en=0: acc and cnt are forced to 0 on every clock. A partial block is discarded. The FIFO keeps draining.
- FIFO: 4 entries, circular, 2-bit read and write pointers plus a 3-bit count.
  - Pop occurs when out_valid & out_ready.
  - Push when not full: the entry is written and the count increments.
  - Push when full with no pop in the same cycle: the sample is dropped, overflow ← 1, and FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: both occur, the count stays 4, and overflow is not set.
  - Push and pop in the same cycle with count 1..3: both occur and the count is unchanged.
  - Pop while empty cannot occur, because out_valid=0.
- overflow: clr_ovf=1 clears it. If clr_ovf and a drop occur in the same cycle, the set wins.
- out_data always reflects the head entry. When the FIFO is empty, out_data holds the last value read (don't-care to the consumer).

## Timing
- Reset (async assert, sync deassert upstream) sets acc=0, cnt=0, pointers=0, out_valid=0, out_data=0, level=0, overflow=0.
- Reset mid-block discards the partial accumulation and all FIFO contents.
- Latency: the completed sample is visible on out_data with out_valid=1 on the clock edge after the ce_1m cycle that completes the block, i.e. 1 cycle.
- Handshake:
  - The transfer happens on the rising edge where out_valid & out_ready are both high.
  - The next entry, if any, appears on the following cycle with no bubble.
  - out_valid does not depend combinationally on out_ready.
- level and overflow are registered and update on the same edge as the push/pop that changes them.
- ce_1m pulses closer than 1 cycle apart do not occur. Back-to-back ce_1m on consecutive cycles must still be handled correctly.

## Test plan
- Constant input: audio_in=18'h20000, en=1, LOG2_DECIM=4, SIGNED_OUT=1, out_ready=1 → one output every 16 ce_1m pulses, out_data=18'h00000, overflow=0.
- Ramp truncation: audio_in = 0,1,…,15 across one block, SIGNED_OUT=0 → out_data=7 (120>>4), out_valid high for 1 cycle.
- Overflow: out_ready=0, full-scale input 18'h3FFFF for 5 blocks → level reaches 4 with data 18'h3FFFF (SIGNED_OUT=0); the 5th sample is dropped and overflow=1. Pulse clr_ovf → overflow=0.
- Full-boundary simultaneity: FIFO at level 4, out_ready=1 on exactly the completing ce_1m cycle → level stays 4, overflow stays 0, and the newest sample is read 4 pops later.
- Reset mid-block: after 7 ce_1m pulses, assert reset asynchronously between edges → all outputs 0 immediately. Next 16 pulses of 18'h00010 yield out_data=18'h00010 (SIGNED_OUT=0).
- Enable gating: en=0 for 10 pulses, then en=1 → no output until 16 further enabled pulses; the first output contains only the enabled samples.

Source files
------------

// File: rtl/sid_audio_decimator.sv
// SID audio box-car decimator with 4-entry output FIFO.
// Averages 2^LOG2_DECIM samples taken on ce_1m; drained via valid/ready.
module sid_audio_decimator #(
  parameter int LOG2_DECIM = 4,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        en,
  input  logic [17:0] audio_in,
  input  logic        out_ready,
  input  logic        clr_ovf,
  output logic        out_valid,
  output logic [17:0] out_data,
  output logic [2:0]  level,
  output logic        overflow
);
  localparam int AW = 18 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] LAST = '1;

  logic [AW-1:0]         acc;
  logic [AW-1:0]         sum;
  logic [LOG2_DECIM-1:0] cnt;
  logic [17:0]           avg;
  logic [17:0]           push_data;
  logic [17:0]           mem [4];
  logic [17:0]           last_rd;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            count;
  logic                  blk_done;
  logic                  pop;
  logic                  full;
  logic                  do_push;
  logic                  drop;

  assign sum       = acc + AW'(audio_in);
  assign avg       = sum[AW-1:LOG2_DECIM];
  assign push_data = SIGNED_OUT ? {~avg[17], avg[16:0]} : avg;

  assign blk_done = ce_1m & en & (cnt == LAST);
  assign full     = count[2];
  assign pop      = out_valid & out_ready;
  assign do_push  = blk_done & (~full | pop);
  assign drop     = blk_done & full & ~pop;

  assign out_valid = (count != 3'd0);
  assign level     = count;
  // Empty FIFO shows the last value popped rather than a stale slot.
  assign out_data  = out_valid ? mem[rd_ptr] : last_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (!en) begin
      acc <= '0;
      cnt <= '0;
    end else if (ce_1m) begin
      if (cnt == LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + LOG2_DECIM'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_rd  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        last_rd <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 2'd1;
      end
      unique case (1'b1)
        do_push & ~pop: count <= count + 3'd1;
        pop & ~do_push: count <= count - 3'd1;
        default: ;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end
endmodule
